minimac3_txbuf: RTL and testbench



---
 rtl/minimac3_pkg.sv | 19 +
 rtl/minimac3_txbuf_ram.sv | 24 ++
 rtl/minimac3_txbuf.sv | 138 +++++++++++++
 tb/tb_minimac3_txbuf.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minimac3_pkg.sv
// Shared definitions for the minimac3 transmit buffer: buffer geometry,
// default frame length limits and the fill/launch state encoding.
package minimac3_pkg;

    localparam int BUF_AW      = 11;
    localparam int BUF_DEPTH   = 1 << BUF_AW;

    localparam int DEF_MIN_LEN = 60;
    localparam int DEF_MAX_LEN = 1536;

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        PAD    = 3'd1,
        DROP   = 3'd2,
        LAUNCH = 3'd3,
        WAIT   = 3'd4
    } txbufState_t;

endpackage

// File: rtl/minimac3_txbuf_ram.sv
// 2048x8 simple dual-port frame buffer: one write port owned by the fill FSM,
// one synchronous read port owned by the nibble transmitter.
module minimac3_txbuf_ram
    import minimac3_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [BUF_AW-1:0] i_wrAdr,
    input  logic [7:0]        i_wrDat,
    input  logic [BUF_AW-1:0] i_rdAdr,
    output logic [7:0]        o_rdDat
);

    logic [7:0] r_mem [0:BUF_DEPTH-1];

    // Storage is left unreset so the array maps onto a block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAdr] <= i_wrDat;
        end
        o_rdDat <= r_mem[i_rdAdr];
    end

endmodule

// File: rtl/minimac3_txbuf.sv
// Transmit frame buffer for the MII nibble transmitter. Collects one frame
// from the byte stream, zero-pads runts, drops oversize frames, then hands
// the frame to the transmitter and holds it until tx_done.
module minimac3_txbuf
    import minimac3_pkg::*;
#(
    parameter int MIN_LEN = DEF_MIN_LEN,
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic              phy_tx_clk,
    input  logic              phy_tx_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_dat,
    input  logic              in_last,
    output logic              tx_start,
    output logic [BUF_AW-1:0] tx_count,
    input  logic              tx_done,
    input  logic [BUF_AW-1:0] txb_adr,
    output logic [7:0]        txb_dat,
    output logic              frame_sent,
    output logic              err_oversize
);

    localparam logic [BUF_AW-1:0] MIN_LEN_W  = BUF_AW'(MIN_LEN);
    localparam logic [BUF_AW-1:0] MIN_LAST_W = BUF_AW'(MIN_LEN - 1);
    localparam logic [BUF_AW-1:0] MAX_LAST_W = BUF_AW'(MAX_LEN - 1);

    txbufState_t       r_state;
    logic [BUF_AW-1:0] r_wrPtr;
    logic              r_inReady;
    logic              r_txStart;
    logic [BUF_AW-1:0] r_txCount;
    logic              r_errOversize;

    logic              w_accept;
    logic              w_wrEn;
    logic [7:0]        w_wrDat;
    logic [BUF_AW-1:0] w_len;

    // Write-port steering: real bytes while filling, zeros while padding.
    always_comb begin
        w_accept = in_valid & r_inReady;
        w_len    = r_wrPtr + BUF_AW'(1);
        w_wrEn   = 1'b0;
        w_wrDat  = in_dat;
        if (r_state == FILL) begin
            w_wrEn = w_accept;
        end else if (r_state == PAD) begin
            w_wrEn  = 1'b1;
            w_wrDat = 8'h00;
        end
    end

    // Frame collection / launch FSM with registered handshake outputs.
    always_ff @(posedge phy_tx_clk or posedge phy_tx_rst) begin
        if (phy_tx_rst) begin
            r_state       <= FILL;
            r_wrPtr       <= '0;
            r_inReady     <= 1'b0;
            r_txStart     <= 1'b0;
            r_txCount     <= '0;
            r_errOversize <= 1'b0;
        end else begin
            r_txStart     <= 1'b0;
            r_errOversize <= 1'b0;
            case (r_state)
                FILL: begin
                    r_inReady <= 1'b1;
                    if (w_accept) begin
                        r_wrPtr <= w_len;
                        if (in_last) begin
                            r_inReady <= 1'b0;
                            if (w_len < MIN_LEN_W) begin
                                r_state <= PAD;
                            end else begin
                                r_txCount <= w_len;
                                r_state   <= LAUNCH;
                            end
                        end else if (r_wrPtr == MAX_LAST_W) begin
                            r_state <= DROP;
                        end
                    end
                end
                PAD: begin
                    r_inReady <= 1'b0;
                    r_wrPtr   <= w_len;
                    if (r_wrPtr == MIN_LAST_W) begin
                        r_txCount <= MIN_LEN_W;
                        r_state   <= LAUNCH;
                    end
                end
                DROP: begin
                    r_inReady <= 1'b1;
                    if (w_accept && in_last) begin
                        r_errOversize <= 1'b1;
                        r_wrPtr       <= '0;
                        r_state       <= FILL;
                    end
                end
                LAUNCH: begin
                    r_inReady <= 1'b0;
                    r_txStart <= 1'b1;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    r_inReady <= 1'b0;
                    if (tx_done) begin
                        r_inReady <= 1'b1;
                        r_wrPtr   <= '0;
                        r_state   <= FILL;
                    end
                end
                default: begin
                    r_inReady <= 1'b0;
                    r_wrPtr   <= '0;
                    r_state   <= FILL;
                end
            endcase
        end
    end

    minimac3_txbuf_ram u_ram (
        .i_clk   (phy_tx_clk),
        .i_wrEn  (w_wrEn),
        .i_wrAdr (r_wrPtr),
        .i_wrDat (w_wrDat),
        .i_rdAdr (txb_adr),
        .o_rdDat (txb_dat)
    );

    assign in_ready     = r_inReady;
    assign tx_start     = r_txStart;
    assign tx_count     = r_txCount;
    assign err_oversize = r_errOversize;
    assign frame_sent   = (r_state == WAIT) & tx_done;

endmodule

// File: tb/tb_minimac3_txbuf.sv
// Directed testbench for minimac3_txbuf: full-rate, runt, max/oversize,
// back-to-back, throttled and reset-recovery frames.
module tb_minimac3_txbuf;

    logic        phy_tx_clk = 1'b0;
    logic        phy_tx_rst = 1'b1;
    logic        in_valid   = 1'b0;
    logic        in_ready;
    logic [7:0]  in_dat     = 8'h00;
    logic        in_last    = 1'b0;
    logic        tx_start;
    logic [10:0] tx_count;
    logic        tx_done    = 1'b0;
    logic [10:0] txb_adr    = 11'd0;
    logic [7:0]  txb_dat;
    logic        frame_sent;
    logic        err_oversize;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] frame [0:2047];

    minimac3_txbuf dut (
        .phy_tx_clk   (phy_tx_clk),
        .phy_tx_rst   (phy_tx_rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dat       (in_dat),
        .in_last      (in_last),
        .tx_start     (tx_start),
        .tx_count     (tx_count),
        .tx_done      (tx_done),
        .txb_adr      (txb_adr),
        .txb_dat      (txb_dat),
        .frame_sent   (frame_sent),
        .err_oversize (err_oversize)
    );

    // 10 ns clock
    always #5 phy_tx_clk = ~phy_tx_clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge phy_tx_clk);
        #1;
    endtask

    // Streams frame[0..n-1]; a byte advances only if in_ready was high before the edge
    task automatic applyStimulus(input int n, input bit gaps, input bit withLast, output bit ok);
        int idx;
        int budget;
        bit wasReady;
        idx    = 0;
        budget = 0;
        ok     = 1'b1;
        while (idx < n) begin
            if (budget > 20000) begin
                ok = 1'b0;
                break;
            end
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                in_valid = 1'b0;
                tick();
                budget++;
                continue;
            end
            in_valid = 1'b1;
            in_dat   = frame[idx];
            in_last  = withLast && (idx == n - 1);
            wasReady = in_ready;
            tick();
            budget++;
            if (wasReady) idx++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Number of cycles until tx_start is seen, -1 if it never comes
    task automatic waitTxStart(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (tx_start === 1'b1) begin
                cycles = c;
                break;
            end
        end
    endtask

    // One-cycle tx_done pulse, reporting frame_sent as seen during it
    task automatic pulseTxDone(output logic sentSeen);
        tx_done = 1'b1;
        #1;
        sentSeen = frame_sent;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        phy_tx_rst = 1'b1;
        tick();
        tick();
        assertCount++;
        if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        assertCount++;
        if (tx_start !== 1'b0) begin failCount++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
        assertCount++;
        if (tx_count !== 11'd0) begin failCount++; $display("[TB] FAIL reset_tx_count: got %0d expected 0", tx_count); end
        assertCount++;
        if (frame_sent !== 1'b0) begin failCount++; $display("[TB] FAIL reset_frame_sent: got %b expected 0", frame_sent); end
        assertCount++;
        if (err_oversize !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %b expected 0", err_oversize); end
        phy_tx_rst = 1'b0;
        #1;
        assertCount++;
        if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_first_cycle_ready: got %b expected 0", in_ready); end
        tick();
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_fill_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_rate();
        bit ok;
        int cyc;
        logic sent;
        for (int i = 0; i < 64; i++) frame[i] = 8'(i);
        applyStimulus(64, 1'b0, 1'b1, ok);
        assertCount++;
        if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL full_send: got %b expected 1", ok); end
        assertCount++;
        if (tx_start !== 1'b0) begin failCount++; $display("[TB] FAIL full_early_start: got %b expected 0", tx_start); end
        waitTxStart(cyc);
        assertCount++;
        if (cyc != 1) begin failCount++; $display("[TB] FAIL full_launch_latency: got %0d expected 1", cyc); end
        assertCount++;
        if (tx_count !== 11'd64) begin failCount++; $display("[TB] FAIL full_tx_count: got %0d expected 64", tx_count); end
        tick();
        assertCount++;
        if (tx_start !== 1'b0) begin failCount++; $display("[TB] FAIL full_start_width: got %b expected 0", tx_start); end
        for (int a = 0; a < 64; a++) begin
            txb_adr = 11'(a);
            tick();
            assertCount++;
            if (txb_dat !== 8'(a)) begin failCount++; $display("[TB] FAIL full_read adr %0d: got %h expected %h", a, txb_dat, 8'(a)); end
        end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL full_frame_sent: got %b expected 1", sent); end
        assertCount++;
        if (frame_sent !== 1'b0) begin failCount++; $display("[TB] FAIL full_sent_width: got %b expected 0", frame_sent); end
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL full_ready_after_done: got %b expected 1", in_ready); end
    endtask

    task automatic test_pad();
        bit ok;
        int cyc;
        int readyHigh;
        logic sent;
        for (int i = 0; i < 10; i++) frame[i] = 8'hA0 + 8'(i);
        applyStimulus(10, 1'b0, 1'b1, ok);
        assertCount++;
        if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL pad_send: got %b expected 1", ok); end
        cyc       = -1;
        readyHigh = 0;
        for (int c = 1; c <= 200; c++) begin
            if (in_ready !== 1'b0) readyHigh++;
            tick();
            if (tx_start === 1'b1) begin
                cyc = c;
                break;
            end
        end
        assertCount++;
        if (cyc != 51) begin failCount++; $display("[TB] FAIL pad_latency: got %0d expected 51", cyc); end
        assertCount++;
        if (readyHigh != 0) begin failCount++; $display("[TB] FAIL pad_ready_low: got %0d ready cycles expected 0", readyHigh); end
        assertCount++;
        if (tx_count !== 11'd60) begin failCount++; $display("[TB] FAIL pad_tx_count: got %0d expected 60", tx_count); end
        for (int a = 0; a < 60; a++) begin
            txb_adr = 11'(a);
            tick();
            assertCount++;
            if (a < 10) begin
                if (txb_dat !== 8'hA0 + 8'(a)) begin failCount++; $display("[TB] FAIL pad_data adr %0d: got %h expected %h", a, txb_dat, 8'hA0 + 8'(a)); end
            end else begin
                if (txb_dat !== 8'h00) begin failCount++; $display("[TB] FAIL pad_zero adr %0d: got %h expected 00", a, txb_dat); end
            end
        end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL pad_frame_sent: got %b expected 1", sent); end
    endtask

    task automatic test_max_and_oversize();
        bit ok;
        int cyc;
        int starts;
        int errs;
        logic sent;
        for (int i = 0; i < 1536; i++) frame[i] = 8'(i) ^ 8'h5A;
        applyStimulus(1536, 1'b0, 1'b1, ok);
        waitTxStart(cyc);
        assertCount++;
        if (cyc != 1) begin failCount++; $display("[TB] FAIL max_launch: got %0d expected 1", cyc); end
        assertCount++;
        if (tx_count !== 11'd1536) begin failCount++; $display("[TB] FAIL max_tx_count: got %0d expected 1536", tx_count); end
        for (int k = 0; k < 3; k++) begin
            int a;
            a = (k == 0) ? 0 : ((k == 1) ? 700 : 1535);
            txb_adr = 11'(a);
            tick();
            assertCount++;
            if (txb_dat !== (8'(a) ^ 8'h5A)) begin failCount++; $display("[TB] FAIL max_read adr %0d: got %h expected %h", a, txb_dat, 8'(a) ^ 8'h5A); end
        end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL max_frame_sent: got %b expected 1", sent); end

        for (int i = 0; i < 1537; i++) frame[i] = 8'(i);
        applyStimulus(1537, 1'b0, 1'b1, ok);
        assertCount++;
        if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL over_send: got %b expected 1", ok); end
        errs   = (err_oversize === 1'b1) ? 1 : 0;
        starts = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (err_oversize === 1'b1) errs++;
            if (tx_start === 1'b1) starts++;
        end
        assertCount++;
        if (errs != 1) begin failCount++; $display("[TB] FAIL over_err_pulses: got %0d expected 1", errs); end
        assertCount++;
        if (starts != 0) begin failCount++; $display("[TB] FAIL over_no_start: got %0d expected 0", starts); end
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL over_ready: got %b expected 1", in_ready); end

        for (int i = 0; i < 60; i++) frame[i] = 8'(i) ^ 8'h33;
        applyStimulus(60, 1'b0, 1'b1, ok);
        waitTxStart(cyc);
        assertCount++;
        if (tx_count !== 11'd60) begin failCount++; $display("[TB] FAIL over_next_count: got %0d expected 60", tx_count); end
        txb_adr = 11'd0;
        tick();
        assertCount++;
        if (txb_dat !== 8'h33) begin failCount++; $display("[TB] FAIL over_next_adr0: got %h expected 33", txb_dat); end
        txb_adr = 11'd59;
        tick();
        assertCount++;
        if (txb_dat !== (8'd59 ^ 8'h33)) begin failCount++; $display("[TB] FAIL over_next_adr59: got %h expected %h", txb_dat, 8'd59 ^ 8'h33); end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL over_next_sent: got %b expected 1", sent); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        logic sent;
        for (int i = 0; i < 64; i++) frame[i] = 8'(i * 3 + 1);
        applyStimulus(64, 1'b0, 1'b1, ok);
        waitTxStart(cyc);
        assertCount++;
        if (cyc != 1) begin failCount++; $display("[TB] FAIL b2b_launch: got %0d expected 1", cyc); end
        in_valid = 1'b1;
        in_dat   = 8'hEE;
        in_last  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            assertCount++;
            if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_wait_ready cycle %0d: got %b expected 0", k, in_ready); end
            txb_adr = 11'(k * 13);
            tick();
            assertCount++;
            if (txb_dat !== 8'(k * 39 + 1)) begin failCount++; $display("[TB] FAIL b2b_first_data adr %0d: got %h expected %h", k * 13, txb_dat, 8'(k * 39 + 1)); end
        end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_frame_sent: got %b expected 1", sent); end
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_ready_after_done: got %b expected 1", in_ready); end
        for (int i = 0; i < 60; i++) frame[i] = 8'hEE - 8'(i);
        applyStimulus(60, 1'b0, 1'b1, ok);
        waitTxStart(cyc);
        assertCount++;
        if (tx_count !== 11'd60) begin failCount++; $display("[TB] FAIL b2b_second_count: got %0d expected 60", tx_count); end
        for (int a = 0; a < 60; a++) begin
            txb_adr = 11'(a);
            tick();
            assertCount++;
            if (txb_dat !== 8'hEE - 8'(a)) begin failCount++; $display("[TB] FAIL b2b_second_data adr %0d: got %h expected %h", a, txb_dat, 8'hEE - 8'(a)); end
        end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_second_sent: got %b expected 1", sent); end
    endtask

    task automatic test_throttled();
        bit ok;
        int cyc;
        logic sent;
        for (int i = 0; i < 100; i++) frame[i] = 8'(i * 7) ^ 8'h81;
        applyStimulus(100, 1'b1, 1'b1, ok);
        assertCount++;
        if (ok !== 1'b1) begin failCount++; $display("[TB] FAIL thr_send: got %b expected 1", ok); end
        waitTxStart(cyc);
        assertCount++;
        if (cyc != 1) begin failCount++; $display("[TB] FAIL thr_launch: got %0d expected 1", cyc); end
        assertCount++;
        if (tx_count !== 11'd100) begin failCount++; $display("[TB] FAIL thr_tx_count: got %0d expected 100", tx_count); end
        for (int a = 0; a < 100; a++) begin
            txb_adr = 11'(a);
            tick();
            assertCount++;
            if (txb_dat !== (8'(a * 7) ^ 8'h81)) begin failCount++; $display("[TB] FAIL thr_data adr %0d: got %h expected %h", a, txb_dat, 8'(a * 7) ^ 8'h81); end
        end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL thr_frame_sent: got %b expected 1", sent); end
    endtask

    task automatic test_reset_recovery();
        bit ok;
        int cyc;
        logic sent;
        for (int i = 0; i < 60; i++) frame[i] = 8'h10 + 8'(i);
        applyStimulus(20, 1'b0, 1'b0, ok);
        phy_tx_rst = 1'b1;
        #1;
        assertCount++;
        if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL rst_fill_ready: got %b expected 0", in_ready); end
        tick();
        phy_tx_rst = 1'b0;
        tick();

        applyStimulus(60, 1'b0, 1'b1, ok);
        waitTxStart(cyc);
        assertCount++;
        if (tx_count !== 11'd60) begin failCount++; $display("[TB] FAIL rst_pre_count: got %0d expected 60", tx_count); end
        tick();
        phy_tx_rst = 1'b1;
        #1;
        assertCount++;
        if (tx_count !== 11'd0) begin failCount++; $display("[TB] FAIL rst_wait_count: got %0d expected 0", tx_count); end
        assertCount++;
        if ({in_ready, tx_start, frame_sent, err_oversize} !== 4'b0000) begin failCount++; $display("[TB] FAIL rst_wait_outputs: got %b expected 0000", {in_ready, tx_start, frame_sent, err_oversize}); end
        tick();
        phy_tx_rst = 1'b0;
        tick();
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b0) begin failCount++; $display("[TB] FAIL rst_stray_done: got %b expected 0", sent); end

        for (int i = 0; i < 60; i++) frame[i] = 8'h99 ^ 8'(i);
        applyStimulus(60, 1'b0, 1'b1, ok);
        waitTxStart(cyc);
        assertCount++;
        if (cyc != 1) begin failCount++; $display("[TB] FAIL rst_post_launch: got %0d expected 1", cyc); end
        assertCount++;
        if (tx_count !== 11'd60) begin failCount++; $display("[TB] FAIL rst_post_count: got %0d expected 60", tx_count); end
        txb_adr = 11'd0;
        tick();
        assertCount++;
        if (txb_dat !== 8'h99) begin failCount++; $display("[TB] FAIL rst_post_adr0: got %h expected 99", txb_dat); end
        txb_adr = 11'd25;
        tick();
        assertCount++;
        if (txb_dat !== (8'h99 ^ 8'd25)) begin failCount++; $display("[TB] FAIL rst_post_adr25: got %h expected %h", txb_dat, 8'h99 ^ 8'd25); end
        pulseTxDone(sent);
        assertCount++;
        if (sent !== 1'b1) begin failCount++; $display("[TB] FAIL rst_post_sent: got %b expected 1", sent); end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_full_rate();
        test_pad();
        test_max_and_oversize();
        test_back_to_back();
        test_throttled();
        test_reset_recovery();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Watchdog against a stuck handshake
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
